timer_bank: RTL and testbench

- Parametrised successor to the single-channel system timer.
- NUM_CH independent down-counting channels of WIDTH bits sit behind one bridge slave port.
- Each channel has a one-shot or auto-reload mode, per-channel interrupt mask and a sticky write-1-to-clear pending flag.
- Per-channel IRQ lines plus an OR-reduced line feed the CPU HWInt vector through the bridge.

---
 rtl/timer_bank_pkg.sv | 30 +++
 rtl/timer_bank_if.sv | 10 +
 rtl/timer_channel.sv | 110 +++++++++++
 rtl/timer_bank.sv | 100 ++++++++++
 tb/tb_timer_bank.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_bank_pkg.sv
// Shared types and constants for the timer_bank channel FSMs and register map.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT,
        ST_IRQ
    } ch_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Packed so that a zero-extending cast yields the CTRL read value directly.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_bank_if.sv
// Bridge-side register bus for timer_bank: write strobe, byte address, write and read data.
interface timer_bank_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/pending registers, FSM and registered irq.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_preset,
    input  logic             wr_status,
    input  logic [31:0]      wdata,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             pending,
    output logic             busy,
    output logic             irq
);

    ch_state_e        state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    logic             irq_q, irq_d;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    // NOTE: every comb output is defaulted to its held value first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (wr_preset) preset_d = wdata[WIDTH-1:0];
        if (wr_status && wdata[0]) pending_d = 1'b0;

        // The FSM runs after the W1C so a same-edge pending set wins.
        unique case (state_q)
            ST_IDLE:  if (ctrl_q.en) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q <= WIDTH'(1)) begin
                        count_d   = '0;
                        pending_d = 1'b1;
                        state_d   = ST_IRQ;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            ST_IRQ: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Applied last so a software CTRL write beats the one-shot EN clear.
        if (wr_ctrl) begin
            ctrl_d.en   = wdata[CTRL_EN];
            ctrl_d.mode = wdata[CTRL_MODE +: 2];
            ctrl_d.im   = wdata[CTRL_IM];
        end

        irq_d = pending_q & ctrl_q.im;
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '{im: 1'b0, mode: MODE_ONESHOT, en: 1'b0};
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign preset  = preset_q;
    assign count   = count_q;
    assign pending = pending_q;
    assign busy    = (state_q == ST_COUNT);
    assign irq     = irq_q;

endmodule

// File: rtl/timer_bank.sv
// NUM_CH timer channels behind one bridge slave port, with per-channel and OR-reduced IRQ lines.
// Define TIMER_BANK_PRESCALE_EN to gate counting with a shared divide-by-PRESCALE tick.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    timer_bank_if.slave       bus,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    logic [1:0]  reg_sel;
    logic [3:0]  ch_sel;
    logic        tick;
    logic [31:0] ch_rdata [NUM_CH];
    logic        unused_addr;

    assign reg_sel     = bus.addr[3:2];
    assign ch_sel      = bus.addr[7:4];
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

`ifdef TIMER_BANK_PRESCALE_EN
    localparam int DIV_W = $clog2(PRESCALE);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = (div_q == DIV_W'(PRESCALE - 1)) ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= div_d;
    end

    assign tick = (div_q == DIV_W'(PRESCALE - 1));
`else
    logic [31:0] unused_prescale;

    assign unused_prescale = 32'(PRESCALE);
    assign tick            = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ctrl_t            ctrl;
        logic [WIDTH-1:0] preset;
        logic [WIDTH-1:0] count;
        logic             pending;
        logic             busy;
        logic             sel;
        logic [31:0]      rd;

        assign sel = bus.we && (ch_sel == 4'(i));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick      (tick),
            .wr_ctrl   (sel && (reg_sel == REG_CTRL)),
            .wr_preset (sel && (reg_sel == REG_PRESET)),
            .wr_status (sel && (reg_sel == REG_STATUS)),
            .wdata     (bus.wdata),
            .ctrl      (ctrl),
            .preset    (preset),
            .count     (count),
            .pending   (pending),
            .busy      (busy),
            .irq       (irq[i])
        );

        always_comb begin
            rd = '0;
            unique case (reg_sel)
                REG_CTRL:   rd = 32'(ctrl);
                REG_PRESET: rd = 32'(preset);
                REG_COUNT:  rd = 32'(count);
                REG_STATUS: rd = {30'b0, busy, pending};
                default:    rd = '0;
            endcase
        end

        assign ch_rdata[i] = rd;
    end

    // Channels at or above NUM_CH never match, so their reads fall through to zero.
    always_comb begin
        bus.rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 4'(i)) bus.rdata = ch_rdata[i];
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank (NUM_CH=3); the TIMER_BANK_PRESCALE_EN build runs the divider test.
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam int NUM_CH = 3;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;
    int                checks = 0;
    int                errors = 0;
    int                cycle  = 0;
    exp_t              sb_q[$];

    timer_bank_if bus();

    timer_bank #(.NUM_CH(NUM_CH), .WIDTH(32), .PRESCALE(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        sb_q.push_back('{tag, val});
    endtask

    task automatic compare(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input int r);
        return 32'(ch * 16 + r * 4);
    endfunction

    task automatic rd(input int ch, input int r, input string tag, input logic [31:0] exp,
                      input logic [31:0] mask = 32'hFFFF_FFFF);
        expect_val(tag, exp);
        bus.addr = ra(ch, r);
        #1;
        compare(bus.rdata & mask);
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.addr  = ra(ch, r);
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pending(input int ch, input int budget, output int n);
        n = 0;
        bus.addr = ra(ch, REG_STATUS);
        #1;
        while (!bus.rdata[0] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, c1, c2, hits;
`ifdef TIMER_BANK_PRESCALE_EN
        int t1, t2, tp;
        logic seen3;
`endif
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int r = 0; r < 4; r++) rd(ch, r, "reset_reg", 32'd0);
        expect_val("reset_irq", 32'd0);
        compare(32'({irq_any, irq}));
        @(negedge clk);
        reset = 1'b1;
        cyc(1);

`ifndef TIMER_BANK_PRESCALE_EN
        // One-shot on ch0: irq rises P+2 edges after the EN write plus one for the irq flop.
        wr(0, REG_PRESET, 32'd5);
        expect_val("oneshot_latency", 32'd8);
        wr(0, REG_CTRL, 32'h9);
        n = 0;
        while (!irq[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        compare(32'(n));
        expect_val("oneshot_irq_any", 32'd1);
        compare(32'(irq_any));
        rd(0, REG_CTRL, "oneshot_ctrl", 32'h8);
        rd(0, REG_COUNT, "oneshot_count", 32'd0);
        rd(0, REG_STATUS, "oneshot_status", 32'h1);
        expect_val("w1c_irq_same_edge", 32'd1);
        wr(0, REG_STATUS, 32'h1);
        compare(32'(irq[0]));
        expect_val("w1c_irq_next_edge", 32'd0);
        cyc(1);
        compare(32'(irq[0]));
        rd(0, REG_STATUS, "w1c_status", 32'h0);

        // Auto-reload, masked, on ch1.
        wr(1, REG_PRESET, 32'd3);
        expect_val("reload_first", 32'd5);
        wr(1, REG_CTRL, 32'h3);
        wait_pending(1, 40, n);
        compare(32'(n));
        c1 = cycle;
        wr(1, REG_STATUS, 32'h1);
        expect_val("reload_period", 32'd5);
        wait_pending(1, 40, n);
        c2 = cycle;
        compare(32'(c2 - c1));
        expect_val("reload_masked_irq", 32'd0);
        compare(32'(irq[1]));

        // Collision: W1C lands on the edge the FSM sets pending again (c2 + 5).
        wr(1, REG_STATUS, 32'h1);
        cyc(3);
        rd(1, REG_STATUS, "collide_pre", 32'h0, 32'h1);
        wr(1, REG_STATUS, 32'h1);
        rd(1, REG_STATUS, "collide_set_wins", 32'h1, 32'h1);

        expect_val("unmask_irq_same_edge", 32'd0);
        wr(1, REG_CTRL, 32'hB);
        compare(32'(irq[1]));
        expect_val("unmask_irq_vec", 32'h2);
        cyc(1);
        compare(32'(irq));
        expect_val("unmask_irq_any", 32'd1);
        compare(32'(irq_any));

        // Disable mid-count on ch2.
        wr(2, REG_PRESET, 32'd100);
        wr(2, REG_CTRL, 32'h1);
        bus.addr = ra(2, REG_COUNT);
        #1;
        n = 0;
        while (bus.rdata != 32'd51 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        wr(2, REG_CTRL, 32'h0);
        cyc(1);
        rd(2, REG_COUNT, "disable_count", 32'd50);
        rd(2, REG_STATUS, "disable_busy", 32'h0);
        cyc(5);
        rd(2, REG_COUNT, "disable_hold", 32'd50);
        wr(2, REG_CTRL, 32'h1);
        cyc(2);
        rd(2, REG_COUNT, "reenable_reload", 32'd100);
        rd(2, REG_STATUS, "reenable_busy", 32'h2);

        // Out-of-range channel.
        wr(3, REG_CTRL, 32'h9);
        wr(3, REG_PRESET, 32'd7);
        rd(3, REG_CTRL, "range_ctrl", 32'd0);
        rd(3, REG_PRESET, "range_preset", 32'd0);
        rd(15, REG_STATUS, "range_ch15", 32'd0);
        rd(0, REG_PRESET, "range_ch0_preset", 32'd5);
        rd(0, REG_CTRL, "range_ch0_ctrl", 32'h8);
        rd(1, REG_PRESET, "range_ch1_preset", 32'd3);
`else
        // Shared divide-by-4 tick gates the decrement and the terminal test.
        wr(0, REG_PRESET, 32'd3);
        wr(0, REG_CTRL, 32'h1);
        t1 = -1;
        t2 = -1;
        tp = -1;
        seen3 = 1'b0;
        for (int k = 0; k < 100 && tp < 0; k++) begin
            bus.addr = ra(0, REG_COUNT);
            #1;
            if (bus.rdata == 32'd3) seen3 = 1'b1;
            if (bus.rdata == 32'd2 && t2 < 0) t2 = cycle;
            if (bus.rdata == 32'd1 && t1 < 0) t1 = cycle;
            bus.addr = ra(0, REG_STATUS);
            #1;
            if (bus.rdata[0] && tp < 0) tp = cycle;
            @(posedge clk);
            #1;
        end
        expect_val("pre_seen3", 32'd1);
        compare(32'(seen3));
        expect_val("pre_step_3_2_1", 32'd4);
        compare(32'(t1 - t2));
        expect_val("pre_step_1_pend", 32'd4);
        compare(32'(tp - t1));
        rd(0, REG_CTRL, "pre_oneshot_ctrl", 32'h0);
        rd(0, REG_COUNT, "pre_final_count", 32'd0);
        wr(1, REG_PRESET, 32'd100);
        wr(1, REG_CTRL, 32'hB);
        cyc(10);
`endif

        // Asynchronous reset in the middle of a cycle while counting.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        expect_val("midreset_irq", 32'd0);
        compare(32'({irq_any, irq}));
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int r = 0; r < 4; r++) rd(ch, r, "midreset_reg", 32'd0);
        @(negedge clk);
        reset = 1'b1;
        hits = 0;
        repeat (200) begin
            @(negedge clk);
            if (irq != '0 || irq_any) hits++;
        end
        expect_val("postreset_quiet", 32'd0);
        compare(32'(hits));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
